rank_filter_3x3: RTL and testbench
==================================

// Module: rank_filter_3x3
// PURPOSE
//  Parametrised 3x3 rank-order filter for the greyscale video path. Selects min, median or max per frame.
//  Sits between the Y-extraction stage and the RGB565 display packer.
//  Contains its own two line buffers and pixel/line counters; no external window generator needed.
//  Adds a frame-latched rank mode, defined top/left edge handling and a sticky overlength-line flag.
// PARAMETERS
//  DATA_W   8    pixel width in bits
//  IMG_W    640  active pixels per line; sets line-buffer depth
//  COL_W    10   column counter width; must satisfy 2**COL_W >= IMG_W+1
// PORTS
//  clk      in   1       pixel clock
//  rst_n    in   1       asynchronous active-low reset
//  i_HSYNC  in   1       horizontal sync, passed through delayed
//  i_VSYNC  in   1       vertical sync, active-low; low = frame boundary
//  i_BLANK  in   1       high = active pixel on i_Y0
//  i_Y0     in   DATA_W  input pixel
//  i_rank   in   2       0 = min, 1 = median, 2 = max, 3 = bypass (centre tap)
//  H_SYNC   out  1       i_HSYNC delayed 4 clk
//  V_SYNC   out  1       i_VSYNC delayed 4 clk
//  BLANK    out  1       i_BLANK delayed 4 clk
//  o_Y0     out  DATA_W  filtered pixel, aligned with BLANK
//  o_ovf    out  1       sticky: a line exceeded IMG_W active pixels this frame
// BEHAVIOUR
//  Reset:
//   - All outputs, counters, window and pipeline registers clear to 0.
//   - Latched rank resets to 1 (median). Line-buffer contents are don't-care.
//  Counters:
//   - col counts active pixels; it clears while i_BLANK = 0.
//   - row increments on each falling edge of i_BLANK; it clears, saturating at 2, while i_VSYNC = 0.
//  Rank latch:
//   - mode <= i_rank on every clk while i_VSYNC = 0.
//   - mode is frozen for the whole frame; i_rank changes mid-frame have no effect.
//  Window:
//   - On an active pixel, the three taps are i_Y0, lb0[col] and lb1[col].
//   - Line-buffer chain: lb1[col] <= lb0[col]; lb0[col] <= i_Y0. Read-before-write at the same address.
//   - Each tap column shifts into a 3x3 register window.
//   - Output (r,c) is centred on input (r-1,c-1).
//  Pipeline (4 clk from i_Y0 to o_Y0):
//   - S1: window update.
//   - S2: per-row sort into max/mid/min.
//   - S3: median = max(mins), med(mids), min(maxes); min = min(mins); max = max(maxes).
//   - S4: final median-of-3, or pass-through for min/max/bypass.
//   - Syncs and BLANK go through a 4-deep shift register; total latency is exactly 4 clk in all modes.
//  Ties: comparisons use >=, so equal values are resolved deterministically. Ordering is unsigned.
//  Edges:
//   - Output row 0 or col 0 (the centre does not exist) -> o_Y0 = 0.
//   - Output row 1 or col 1 (top/left taps missing) -> see CONFIGURATION.
//  Inactive cycles: o_Y0 = 0 whenever the delayed BLANK = 0.
//  Overlength line:
//   - Pixels with col >= IMG_W are not written to the line buffers; their output is 0.
//   - col saturates at IMG_W.
//   - o_ovf is set at the first such pixel and cleared only while i_VSYNC = 0.
//  rst_n asserted mid-frame: immediate clear. Filtering restarts cleanly from the next frame boundary.
// CONFIGURATION
//  RANK_BORDER_REPLICATE_EN defined:
//   - Missing top/left taps are replaced by the nearest in-image tap (row/column replication).
//   - Rank filtering then applies at row 1 / col 1.
//  RANK_BORDER_REPLICATE_EN undefined:
//   - At output row 1 or col 1, o_Y0 = centre tap unfiltered.
//  Latency and the IMG_W limit are identical in both builds.
// TESTING
//  1. Reset: hold rst_n = 0 for 5 clk, then release -> all outputs 0; first frame runs in median mode.
//  2. Impulse: IMG_W = 8, all pixels 10 except one 255 at (4,4), i_rank = 1 -> output (5,5) = 10; no 255 on o_Y0.
//  3. Mode latch: i_rank = 2 during VSYNC, switched to 0 mid-frame -> whole frame is max; the 255 spike dilates to a 3x3 block.
//  4. Latency: ramp i_Y0 = col, i_rank = 3 -> o_Y0 equals the centre tap; BLANK/H_SYNC/V_SYNC edges appear exactly 4 clk after the inputs.
//  5. Edges: uniform 50 image -> rows/cols 0 = 0. Row/col 1 = 50 in both builds. A gradient shows replicate vs. pass-through differences.
//  6. Overlength: line of IMG_W+3 active pixels -> o_ovf = 1 from pixel IMG_W until the next VSYNC low; later lines are unaffected.

Source files
------------

// File: rtl/rank_filter_3x3.sv
// rank_filter_3x3: 3x3 min/median/max/bypass filter with internal line buffers, 4 clk latency.
// Build option RANK_BORDER_REPLICATE_EN: replicate missing top/left taps instead of passing the centre.
module rank_filter_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int COL_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_HSYNC,
  input  logic              i_VSYNC,
  input  logic              i_BLANK,
  input  logic [DATA_W-1:0] i_Y0,
  input  logic [1:0]        i_rank,
  output logic              H_SYNC,
  output logic              V_SYNC,
  output logic              BLANK,
  output logic [DATA_W-1:0] o_Y0,
  output logic              o_ovf
);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W);

  typedef logic [DATA_W-1:0] pix_t;
  typedef enum logic [1:0] {R_MIN = 2'd0, R_MED = 2'd1, R_MAX = 2'd2, R_BYP = 2'd3} rank_t;

  function automatic pix_t max2(pix_t a, pix_t b);
    return (a >= b) ? a : b;
  endfunction

  function automatic pix_t min2(pix_t a, pix_t b);
    return (a >= b) ? b : a;
  endfunction

  function automatic pix_t max3(pix_t a, pix_t b, pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t min3(pix_t a, pix_t b, pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t med3(pix_t a, pix_t b, pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic             blank_q;
  rank_t            mode_q, mode_d;
  logic             ovf_q, ovf_d;
  logic             in_img;
  logic [AW-1:0]    addr;
  pix_t             tap1, tap2;
  pix_t             lb0 [IMG_W];
  pix_t             lb1 [IMG_W];

  // S0: counters, frame-latched rank, overlength flag, line-buffer read
  always_comb begin
    in_img = i_BLANK && (col_q < COL_MAX);
    addr   = in_img ? col_q[AW-1:0] : '0;
    tap1   = lb0[addr];
    tap2   = lb1[addr];

    col_d = col_q;
    if (!i_BLANK)
      col_d = '0;
    else if (col_q != COL_MAX)
      col_d = col_q + COL_W'(1);

    row_d = row_q;
    if (!i_VSYNC)
      row_d = 2'd0;
    else if (blank_q && !i_BLANK && row_q != 2'd2)
      row_d = row_q + 2'd1;

    mode_d = i_VSYNC ? mode_q : rank_t'(i_rank);

    ovf_d = ovf_q;
    if (!i_VSYNC)
      ovf_d = 1'b0;
    else if (i_BLANK && col_q == COL_MAX)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= 2'd0;
      blank_q <= 1'b0;
      mode_q  <= R_MED;
      ovf_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      blank_q <= i_BLANK;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  // Read-before-write chain: the old lb0 entry moves down to lb1.
  always_ff @(posedge clk) begin
    if (in_img) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= i_Y0;
    end
  end

  // S1: 3x3 window; row 0 = current line, column 0 = newest pixel, [1][1] = centre
  pix_t  win_p1_q [3][3];
  logic  vld_p1_q, top_p1_q, left_p1_q;
  rank_t mode_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p1_q  <= '{default: '0};
      vld_p1_q  <= 1'b0;
      top_p1_q  <= 1'b0;
      left_p1_q <= 1'b0;
      mode_p1_q <= R_MIN;
    end else begin
      vld_p1_q  <= in_img && (row_q != 2'd0) && (col_q != '0);
      top_p1_q  <= (row_q == 2'd1);
      left_p1_q <= (col_q == COL_W'(1));
      mode_p1_q <= mode_q;
      if (in_img) begin
        win_p1_q[0][0] <= i_Y0;
        win_p1_q[1][0] <= tap1;
        win_p1_q[2][0] <= tap2;
        for (int i = 0; i < 3; i++) begin
          win_p1_q[i][1] <= win_p1_q[i][0];
          win_p1_q[i][2] <= win_p1_q[i][1];
        end
      end
    end
  end

  // S2: border handling, then per-row sort
  pix_t  win_s [3][3];
  logic  pass_p2_d;
  pix_t  hi_p2_q [3];
  pix_t  mi_p2_q [3];
  pix_t  lo_p2_q [3];
  pix_t  ctr_p2_q;
  logic  vld_p2_q, pass_p2_q;
  rank_t mode_p2_q;

  always_comb begin
    win_s = win_p1_q;
`ifdef RANK_BORDER_REPLICATE_EN
    pass_p2_d = 1'b0;
    if (top_p1_q)
      for (int j = 0; j < 3; j++) win_s[2][j] = win_s[1][j];
    if (left_p1_q)
      for (int i = 0; i < 3; i++) win_s[i][2] = win_s[i][1];
`else
    pass_p2_d = top_p1_q || left_p1_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_p2_q   <= '{default: '0};
      mi_p2_q   <= '{default: '0};
      lo_p2_q   <= '{default: '0};
      ctr_p2_q  <= '0;
      vld_p2_q  <= 1'b0;
      pass_p2_q <= 1'b0;
      mode_p2_q <= R_MIN;
    end else begin
      for (int i = 0; i < 3; i++) begin
        hi_p2_q[i] <= max3(win_s[i][0], win_s[i][1], win_s[i][2]);
        mi_p2_q[i] <= med3(win_s[i][0], win_s[i][1], win_s[i][2]);
        lo_p2_q[i] <= min3(win_s[i][0], win_s[i][1], win_s[i][2]);
      end
      ctr_p2_q  <= win_p1_q[1][1];
      vld_p2_q  <= vld_p1_q;
      pass_p2_q <= pass_p2_d;
      mode_p2_q <= mode_p1_q;
    end
  end

  // S3: column reduction; a carries the result for every mode except median
  pix_t a_p3_d, b_p3_d, c_p3_d;
  logic med_p3_d;
  pix_t a_p3_q, b_p3_q, c_p3_q;
  logic med_p3_q, vld_p3_q;

  always_comb begin
    a_p3_d   = ctr_p2_q;
    b_p3_d   = '0;
    c_p3_d   = '0;
    med_p3_d = 1'b0;
    if (!pass_p2_q) begin
      case (mode_p2_q)
        R_MIN: a_p3_d = min3(lo_p2_q[0], lo_p2_q[1], lo_p2_q[2]);
        R_MAX: a_p3_d = max3(hi_p2_q[0], hi_p2_q[1], hi_p2_q[2]);
        R_MED: begin
          a_p3_d   = max3(lo_p2_q[0], lo_p2_q[1], lo_p2_q[2]);
          b_p3_d   = med3(mi_p2_q[0], mi_p2_q[1], mi_p2_q[2]);
          c_p3_d   = min3(hi_p2_q[0], hi_p2_q[1], hi_p2_q[2]);
          med_p3_d = 1'b1;
        end
        default: a_p3_d = ctr_p2_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p3_q   <= '0;
      b_p3_q   <= '0;
      c_p3_q   <= '0;
      med_p3_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      a_p3_q   <= a_p3_d;
      b_p3_q   <= b_p3_d;
      c_p3_q   <= c_p3_d;
      med_p3_q <= med_p3_d;
      vld_p3_q <= vld_p2_q;
    end
  end

  // S4: final select; syncs ride a matching 4-deep shift register
  pix_t       y_p4_q;
  logic [2:0] sync_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p4_q <= '0;
      sync_q <= '{default: '0};
    end else begin
      if (!vld_p3_q)
        y_p4_q <= '0;
      else if (med_p3_q)
        y_p4_q <= med3(a_p3_q, b_p3_q, c_p3_q);
      else
        y_p4_q <= a_p3_q;
      sync_q[0] <= {i_HSYNC, i_VSYNC, i_BLANK};
      for (int i = 1; i < 4; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {H_SYNC, V_SYNC, BLANK} = sync_q[3];
  assign o_Y0  = y_p4_q;
  assign o_ovf = ovf_q;

endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed bench for rank_filter_3x3 (IMG_W = 8): frames are captured by position, then checked from a table.
module tb_rank_filter_3x3;
  localparam int IMG_W = 8;
  localparam int NR    = 7;
  localparam int NC    = 12;
  localparam int NF    = 6;
  localparam int HN    = 1024;

`ifdef RANK_BORDER_REPLICATE_EN
  localparam int E13 = 2;
  localparam int E31 = 11;
`else
  localparam int E13 = 3;
  localparam int E31 = 21;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_HSYNC, i_VSYNC, i_BLANK;
  logic [7:0] i_Y0;
  logic [1:0] i_rank;
  logic       H_SYNC, V_SYNC, BLANK, o_ovf;
  logic [7:0] o_Y0;

  rank_filter_3x3 #(.DATA_W(8), .IMG_W(IMG_W), .COL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_HSYNC(i_HSYNC), .i_VSYNC(i_VSYNC), .i_BLANK(i_BLANK), .i_Y0(i_Y0), .i_rank(i_rank),
    .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .BLANK(BLANK), .o_Y0(o_Y0), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit h, v, b;
    int fi, r, c;
  } hist_t;

  typedef struct {
    string name;
    int    kind;   // 0 = captured pixel, 1 = o_ovf right after that input pixel
    int    fi, r, c;
    int    exp;
  } vec_t;

  hist_t hist [HN];
  int    cap    [NF][NR][NC];
  int    ovf_tr [NF][NR][NC];
  vec_t  tbl [$];
  int    cyc, frame_err;
  int    n_cmp, n_bad;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input string name, input int kind, input int fi,
                              input int r, input int c, input int exp);
    vec_t v;
    v.name = name; v.kind = kind; v.fi = fi; v.r = r; v.c = c; v.exp = exp;
    tbl.push_back(v);
  endfunction

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0:       return (r == 4 && c == 4) ? 8'd255 : 8'd10;
      1:       return 8'(16 * r + c + 1);
      2:       return 8'd50;
      default: return (c >= IMG_W) ? 8'd200 : 8'(10 * r + c + 1);
    endcase
  endfunction

  // One clock: drive at negedge, sample at the next negedge; outputs then reflect the input of 3 drives ago.
  task automatic drive(input bit h, input bit v, input bit b, input logic [7:0] y,
                       input int fi, input int r, input int c);
    hist_t e;
    i_HSYNC = h; i_VSYNC = v; i_BLANK = b; i_Y0 = y;
    e.h = h; e.v = v; e.b = b; e.fi = fi; e.r = r; e.c = c;
    hist[cyc % HN] = e;
    @(posedge clk);
    @(negedge clk);
    e = hist[(cyc + HN - 3) % HN];
    if (H_SYNC !== e.h || V_SYNC !== e.v || BLANK !== e.b) frame_err++;
    if (!e.b && o_Y0 !== 8'd0) frame_err++;
    if (e.b && e.fi >= 0 && e.r < NR && e.c < NC) cap[e.fi][e.r][e.c] = int'(o_Y0);
    if (b && fi >= 0 && r < NR && c < NC) ovf_tr[fi][r][c] = int'(o_ovf);
    cyc++;
  endtask

  task automatic run_frame(input int fi, input int pat, input int rk0, input int rk1,
                           input bit vs_pre, input int long_row);
    int n;
    frame_err = 0;
    i_rank = 2'(rk0);
    if (vs_pre)
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 8'd0, -1, 0, 0);
    for (int r = 0; r < NR; r++) begin
      n = (r == long_row) ? IMG_W + 3 : IMG_W;
      if (r == 3) i_rank = 2'(rk1);
      drive(1'b1, 1'b1, 1'b0, 8'd0, -1, 0, 0);
      drive(1'b0, 1'b1, 1'b0, 8'd0, -1, 0, 0);
      for (int c = 0; c < n; c++) drive(1'b0, 1'b1, 1'b1, pix(pat, r, c), fi, r, c);
    end
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 1'b0, 8'd0, -1, 0, 0);
    check($sformatf("sync_align_f%0d", fi), frame_err, 0);
  endtask

  initial begin
    int n255;
    n_cmp = 0; n_bad = 0; cyc = 0; frame_err = 0;
    for (int i = 0; i < HN; i++) begin
      hist[i].h = 1'b0; hist[i].v = 1'b0; hist[i].b = 1'b0;
      hist[i].fi = -1; hist[i].r = 0; hist[i].c = 0;
    end
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++) begin
          cap[f][r][c] = -1;
          ovf_tr[f][r][c] = -1;
        end

    // f0: impulse, reset-default median even though i_rank = max is driven
    add("f0_med_55", 0, 0, 5, 5, 10);
    add("f0_med_44", 0, 0, 4, 4, 10);
    add("f0_med_66", 0, 0, 6, 6, 10);
    add("f0_row0",   0, 0, 0, 3, 0);
    add("f0_col0",   0, 0, 3, 0, 0);
    add("f0_row1",   0, 0, 1, 3, 10);
    add("f0_col1",   0, 0, 3, 1, 10);
    // f1: max latched during VSYNC, i_rank = min from row 3 on
    add("f1_max_44", 0, 1, 4, 4, 255);
    add("f1_max_66", 0, 1, 6, 6, 255);
    add("f1_max_46", 0, 1, 4, 6, 255);
    add("f1_max_64", 0, 1, 6, 4, 255);
    add("f1_max_35", 0, 1, 3, 5, 10);
    add("f1_max_57", 0, 1, 5, 7, 10);
    add("f1_max_53", 0, 1, 5, 3, 10);
    // f2: ramp 16r+c+1, bypass -> input (r-1,c-1)
    add("f2_byp_11", 0, 2, 1, 1, 1);
    add("f2_byp_35", 0, 2, 3, 5, 37);
    add("f2_byp_67", 0, 2, 6, 7, 87);
    add("f2_byp_41", 0, 2, 4, 1, 49);
    add("f2_row0",   0, 2, 0, 5, 0);
    add("f2_col0",   0, 2, 2, 0, 0);
    // f3: uniform 50, median
    add("f3_11",     0, 3, 1, 1, 50);
    add("f3_14",     0, 3, 1, 4, 50);
    add("f3_41",     0, 3, 4, 1, 50);
    add("f3_33",     0, 3, 3, 3, 50);
    add("f3_00",     0, 3, 0, 0, 0);
    add("f3_04",     0, 3, 0, 4, 0);
    add("f3_40",     0, 3, 4, 0, 0);
    // f4: gradient 10r+c+1, min; row/col 1 differ between builds
    add("f4_min_33", 0, 4, 3, 3, 12);
    add("f4_min_56", 0, 4, 5, 6, 35);
    add("f4_min_27", 0, 4, 2, 7, 6);
    add("f4_min_11", 0, 4, 1, 1, 1);
    add("f4_edge13", 0, 4, 1, 3, E13);
    add("f4_edge31", 0, 4, 3, 1, E31);
    add("f4_ovf_end", 1, 4, 6, 7, 0);
    // f5: gradient, bypass, row 2 has IMG_W+3 active pixels
    add("f5_long_8",  0, 5, 2, 8, 0);
    add("f5_long_9",  0, 5, 2, 9, 0);
    add("f5_long_10", 0, 5, 2, 10, 0);
    add("f5_byp_27",  0, 5, 2, 7, 17);
    add("f5_byp_31",  0, 5, 3, 1, 21);
    add("f5_byp_32",  0, 5, 3, 2, 22);
    add("f5_byp_33",  0, 5, 3, 3, 23);
    add("f5_byp_44",  0, 5, 4, 4, 34);
    add("f5_ovf_27",  1, 5, 2, 7, 0);
    add("f5_ovf_28",  1, 5, 2, 8, 1);
    add("f5_ovf_210", 1, 5, 2, 10, 1);
    add("f5_ovf_end", 1, 5, 6, 7, 1);

    rst_n = 1'b0;
    i_HSYNC = 1'b0; i_VSYNC = 1'b1; i_BLANK = 1'b0; i_Y0 = 8'd0; i_rank = 2'd2;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_o_Y0",   int'(o_Y0),   0);
    check("rst_BLANK",  int'(BLANK),  0);
    check("rst_H_SYNC", int'(H_SYNC), 0);
    check("rst_V_SYNC", int'(V_SYNC), 0);
    check("rst_o_ovf",  int'(o_ovf),  0);
    rst_n = 1'b1;

    run_frame(0, 0, 2, 2, 1'b0, -1);
    run_frame(1, 0, 2, 0, 1'b1, -1);
    run_frame(2, 1, 3, 3, 1'b1, -1);
    run_frame(3, 2, 1, 1, 1'b1, -1);
    run_frame(4, 3, 0, 0, 1'b1, -1);
    run_frame(5, 3, 3, 3, 1'b1, 2);

    drive(1'b0, 1'b0, 1'b0, 8'd0, -1, 0, 0);
    check("ovf_clear_on_vsync", int'(o_ovf), 0);
    drive(1'b0, 1'b1, 1'b0, 8'd0, -1, 0, 0);

    n255 = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IMG_W; c++)
        if (cap[0][r][c] == 255) n255++;
    check("f0_no_spike", n255, 0);

    foreach (tbl[i]) begin
      if (tbl[i].kind == 0)
        check(tbl[i].name, cap[tbl[i].fi][tbl[i].r][tbl[i].c], tbl[i].exp);
      else
        check(tbl[i].name, ovf_tr[tbl[i].fi][tbl[i].r][tbl[i].c], tbl[i].exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
